// File: rtl/sharpen_window_gen.sv
// sharpen_window_gen: takes a raster-order pixel stream and builds 3x3
// neighbourhood windows using two line buffers. One window is presented per
// interior pixel through a valid/ready output register.
//
// Optional build macro SHARPEN_WIN_SOF_EN adds OUT_SOF, flagging the first
// window of each frame.
//
// Window layout: element k = 3*r + c at OUT_WIN[PIX_W*k +: PIX_W], where r=0 is
// the oldest row, c=0 the oldest column, and k=4 is the centre.
module sharpen_window_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [PIX_W-1:0]   IN_PIX,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [9*PIX_W-1:0] OUT_WIN,
`ifdef SHARPEN_WIN_SOF_EN
    output logic               OUT_SOF,
`endif
    output logic               FRAME_DONE
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // Elaboration-time parameter sanity.
    if (IMG_W < 3) begin : g_bad_w
        $error("sharpen_window_gen: IMG_W must be at least 3");
    end
    if (IMG_H < 3) begin : g_bad_h
        $error("sharpen_window_gen: IMG_H must be at least 3");
    end
    if ((CNT_W < AW) || ((2 ** CNT_W) < IMG_H) || ((2 ** CNT_W) < IMG_W)) begin : g_bad_cnt
        $error("sharpen_window_gen: CNT_W too narrow for image size");
    end

    // Stage p0: counters, line buffers and the sliding window registers.
    logic [CNT_W-1:0] col_p0;
    logic [CNT_W-1:0] row_p0;
    logic [AW-1:0]    col_idx_p0;
    logic             col_last_p0;
    logic             row_last_p0;
    logic             accept_p0;
    logic             emit_p0;

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] tap0_p0;
    logic [PIX_W-1:0] tap1_p0;

    logic [PIX_W-1:0]   win_p0      [9];
    logic [PIX_W-1:0]   win_next_p0 [9];
    logic [9*PIX_W-1:0] win_flat_p0;

    // Stage p1: output register slice.
    logic               vld_p1;
    logic [9*PIX_W-1:0] win_p1;
    logic               done_p1;
`ifdef SHARPEN_WIN_SOF_EN
    logic               sof_p1;
`endif

    assign IN_READY    = !vld_p1 || OUT_READY;
    assign accept_p0   = IN_VALID && IN_READY;
    assign col_idx_p0  = col_p0[AW-1:0];
    assign col_last_p0 = (col_p0 == CNT_W'(IMG_W - 1));
    assign row_last_p0 = (row_p0 == CNT_W'(IMG_H - 1));
    assign emit_p0     = accept_p0 && (row_p0 >= CNT_W'(2)) && (col_p0 >= CNT_W'(2));

    // Line buffers are read asynchronously so the pre-write values feed the window.
    assign tap0_p0 = lb0[col_idx_p0];
    assign tap1_p0 = lb1[col_idx_p0];

    // Column/row raster position of the next pixel to be accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (accept_p0) begin
            if (col_last_p0) begin
                col_p0 <= '0;
                row_p0 <= row_last_p0 ? '0 : row_p0 + CNT_W'(1);
            end else begin
                col_p0 <= col_p0 + CNT_W'(1);
            end
        end
    end

    // Age the column history: row-1 moves to row-2, the new pixel becomes row-1.
    always_ff @(posedge CLK) begin
        if (accept_p0) begin
            lb0[col_idx_p0] <= tap1_p0;
            lb1[col_idx_p0] <= IN_PIX;
        end
    end

    // Next window: shift columns left and load {row-2, row-1, new} as column 2.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            win_next_p0[k] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            win_next_p0[3*r]     = win_p0[3*r + 1];
            win_next_p0[3*r + 1] = win_p0[3*r + 2];
        end
        win_next_p0[2] = tap0_p0;
        win_next_p0[5] = tap1_p0;
        win_next_p0[8] = IN_PIX;
    end

    // Flatten the next window into the output bus layout.
    always_comb begin
        win_flat_p0 = '0;
        for (int k = 0; k < 9; k++) begin
            win_flat_p0[PIX_W*k +: PIX_W] = win_next_p0[k];
        end
    end

    // Sliding window registers advance on every accepted pixel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 9; k++) begin
                win_p0[k] <= '0;
            end
        end else if (accept_p0) begin
            for (int k = 0; k < 9; k++) begin
                win_p0[k] <= win_next_p0[k];
            end
        end
    end

    // Output slice: load on an emitting accept, clear on a bare handshake, else hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            win_p1  <= '0;
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= accept_p0 && col_last_p0 && row_last_p0;
            if (emit_p0) begin
                vld_p1 <= 1'b1;
                win_p1 <= win_flat_p0;
            end else if (OUT_READY) begin
                vld_p1 <= 1'b0;
            end
        end
    end

`ifdef SHARPEN_WIN_SOF_EN
    // First-window flag travels with the window and holds under backpressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sof_p1 <= 1'b0;
        end else if (emit_p0) begin
            sof_p1 <= (row_p0 == CNT_W'(2)) && (col_p0 == CNT_W'(2));
        end else if (OUT_READY) begin
            sof_p1 <= 1'b0;
        end
    end

    assign OUT_SOF = sof_p1;
`endif

    assign OUT_VALID  = vld_p1;
    assign OUT_WIN    = win_p1;
    assign FRAME_DONE = done_p1;

endmodule

// File: tb/tb_sharpen_window_gen.sv
// Bench for sharpen_window_gen on a 4x4 image: an image-array reference model
// is checked every cycle, plus literal window lists for the directed streams.
module tb_sharpen_window_gen;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int WW    = 9 * PIX_W;

    logic           CLK = 1'b0;
    logic           RST;
    logic           IN_VALID;
    logic           IN_READY;
    logic [PIX_W-1:0] IN_PIX;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [WW-1:0]  OUT_WIN;
    logic           FRAME_DONE;
`ifdef SHARPEN_WIN_SOF_EN
    logic           OUT_SOF;
`endif

    sharpen_window_gen #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_PIX(IN_PIX),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_WIN(OUT_WIN),
`ifdef SHARPEN_WIN_SOF_EN
        .OUT_SOF(OUT_SOF),
`endif
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Reference model state (image-array based).
    logic [PIX_W-1:0] img [0:IMG_H-1][0:IMG_W-1];
    logic             m_vld  = 1'b0;
    logic [WW-1:0]    m_win  = '0;
    logic             m_done = 1'b0;
    logic             m_sof  = 1'b0;
    int               m_row  = 0;
    int               m_col  = 0;
    int               acc_total = 0;
    logic             m_acc;
    logic [WW-1:0]    m_w;

    // Stimulus source and collected/expected windows.
    logic [PIX_W-1:0] src [0:63];
    logic [WW-1:0]    got_q [$];
    logic [WW-1:0]    exp_q [$];
    logic             sof_q [$];
    int               done_cnt = 0;
    logic [WW-1:0]    stall_win;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [WW-1:0] lit9(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        logic [WW-1:0] w;
        w = {a8[PIX_W-1:0], a7[PIX_W-1:0], a6[PIX_W-1:0], a5[PIX_W-1:0], a4[PIX_W-1:0],
             a3[PIX_W-1:0], a2[PIX_W-1:0], a1[PIX_W-1:0], a0[PIX_W-1:0]};
        return w;
    endfunction

    // Expected interior windows of one frame stored at src[off...].
    task automatic add_frame_exp(input int off);
        logic [WW-1:0] w;
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                w = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        w[PIX_W*(3*i+j) +: PIX_W] = src[off + (r-2+i)*IMG_W + (c-2+j)];
                    end
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic push_lit_4x4(input int base);
        exp_q.push_back(lit9(base+0, base+1, base+2, base+4, base+5, base+6, base+8, base+9, base+10));
        exp_q.push_back(lit9(base+1, base+2, base+3, base+5, base+6, base+7, base+9, base+10, base+11));
        exp_q.push_back(lit9(base+4, base+5, base+6, base+8, base+9, base+10, base+12, base+13, base+14));
        exp_q.push_back(lit9(base+5, base+6, base+7, base+9, base+10, base+11, base+13, base+14, base+15));
    endtask

    task automatic cmp_list(input string name);
        chk({name, "_count"}, WW'(got_q.size()), WW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(name, got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_lists();
        got_q.delete();
        exp_q.delete();
        sof_q.delete();
        done_cnt = 0;
    endtask

    // Reference model: handshake rules plus windows read from the image array.
    always @(posedge CLK) begin
        if (RST) begin
            m_vld  <= 1'b0;
            m_win  <= '0;
            m_done <= 1'b0;
            m_sof  <= 1'b0;
            m_row  <= 0;
            m_col  <= 0;
        end else begin
            m_acc = IN_VALID && (!m_vld || OUT_READY);
            m_done <= m_acc && (m_row == IMG_H-1) && (m_col == IMG_W-1);
            if (m_acc) begin
                acc_total <= acc_total + 1;
                img[m_row][m_col] <= IN_PIX;
                if (m_row >= 2 && m_col >= 2) begin
                    m_w = '0;
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            m_w[PIX_W*(3*r+c) +: PIX_W] = (r == 2 && c == 2) ? IN_PIX
                                                        : img[m_row-2+r][m_col-2+c];
                        end
                    end
                    m_vld <= 1'b1;
                    m_win <= m_w;
                    m_sof <= (m_row == 2 && m_col == 2);
                end else if (OUT_READY) begin
                    m_vld <= 1'b0;
                    m_sof <= 1'b0;
                end
                if (m_col == IMG_W-1) begin
                    m_col <= 0;
                    m_row <= (m_row == IMG_H-1) ? 0 : m_row + 1;
                end else begin
                    m_col <= m_col + 1;
                end
            end else if (OUT_READY) begin
                m_vld <= 1'b0;
                m_sof <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge CLK) begin
        if (checking) begin
            chk("in_ready", WW'(IN_READY), WW'(!m_vld || OUT_READY));
            chk("out_valid", WW'(OUT_VALID), WW'(m_vld));
            chk("frame_done", WW'(FRAME_DONE), WW'(m_done));
            if (m_vld) begin
                chk("out_win", OUT_WIN, m_win);
`ifdef SHARPEN_WIN_SOF_EN
                chk("out_sof", WW'(OUT_SOF), WW'(m_sof));
`endif
            end
            if (!RST && m_vld && OUT_READY) begin
                got_q.push_back(OUT_WIN);
`ifdef SHARPEN_WIN_SOF_EN
                sof_q.push_back(OUT_SOF);
`else
                sof_q.push_back(1'b0);
`endif
            end
            if (FRAME_DONE) done_cnt++;
        end
    end

    // Drive n pixels from src[0..n-1]; vmode 1 = random gaps; rmode 0 = ready,
    // 1 = 5-cycle stall after the first window, 2 = random ready.
    task automatic run(input int n, input int vmode, input int rmode, input int budget);
        int base;
        int idx;
        int cyc;
        int stall;
        bit stalled;
        base = acc_total;
        cyc = 0;
        stall = 0;
        stalled = 1'b0;
        while (((acc_total - base) < n || m_vld) && cyc < budget) begin
            idx = acc_total - base;
            IN_VALID = (idx < n) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
            IN_PIX   = (idx < n) ? src[idx] : '0;
            if (rmode == 1) begin
                if (m_vld && !stalled) begin
                    stall = 5;
                    stalled = 1'b1;
                end
                if (stall > 0) begin
                    OUT_READY = 1'b0;
                    stall--;
                    @(negedge CLK);
                    chk("stall_win", OUT_WIN, stall_win);
                    chk("stall_in_ready", WW'(IN_READY), WW'(0));
                end else begin
                    OUT_READY = 1'b1;
                end
            end else begin
                OUT_READY = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        if (cyc >= budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: got %0d accepts expected %0d", acc_total - base, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        IN_VALID = 1'b0;
        IN_PIX = '0;
        OUT_READY = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", WW'(OUT_VALID), WW'(0));
        chk("rst_out_win", OUT_WIN, WW'(0));
        chk("rst_frame_done", WW'(FRAME_DONE), WW'(0));
        chk("rst_in_ready", WW'(IN_READY), WW'(1));
        checking = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        OUT_READY = 1'b1;

        // Gap-free single frame, pixel = index.
        for (int i = 0; i < 16; i++) src[i] = PIX_W'(i);
        clear_lists();
        run(16, 0, 0, 200);
        push_lit_4x4(0);
        cmp_list("t1_windows");
        chk("t1_done_pulses", WW'(done_cnt), WW'(1));

        // Same stream with a 5-cycle stall after the first window.
        clear_lists();
        stall_win = lit9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        run(16, 0, 1, 200);
        push_lit_4x4(0);
        cmp_list("t2_windows");
        chk("t2_done_pulses", WW'(done_cnt), WW'(1));

        // Same stream with random input gaps and random output ready.
        clear_lists();
        run(16, 1, 2, 1000);
        push_lit_4x4(0);
        cmp_list("t3_windows");

        // Two back-to-back frames, second frame pixel = 100 + index.
        for (int i = 0; i < 16; i++) src[16+i] = PIX_W'(100 + i);
        clear_lists();
        run(32, 0, 0, 200);
        if (got_q.size() > 4) begin
            chk("t4_frame2_first", got_q[4], lit9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL t4_frame2_first: got %0d windows expected 8", got_q.size());
        end
        push_lit_4x4(0);
        push_lit_4x4(100);
        cmp_list("t4_windows");
        chk("t4_done_pulses", WW'(done_cnt), WW'(2));
`ifdef SHARPEN_WIN_SOF_EN
        for (int i = 0; i < sof_q.size(); i++) begin
            chk("t4_sof", WW'(sof_q[i]), WW'((i % 4) == 0));
        end
`endif

        // Three random-content frames with random gaps and random ready.
        for (int i = 0; i < 48; i++) src[i] = PIX_W'($urandom);
        clear_lists();
        run(48, 1, 2, 3000);
        add_frame_exp(0);
        add_frame_exp(16);
        add_frame_exp(32);
        cmp_list("t5_random");
        chk("t5_done_pulses", WW'(done_cnt), WW'(3));
`ifdef SHARPEN_WIN_SOF_EN
        for (int i = 0; i < sof_q.size(); i++) begin
            chk("t5_sof", WW'(sof_q[i]), WW'((i % 4) == 0));
        end
`endif

        // Reset mid-frame after pixel 9, then a fresh frame of 50 + index.
        for (int i = 0; i < 16; i++) src[i] = PIX_W'(i);
        clear_lists();
        run(10, 0, 0, 100);
        chk("t6_pre_reset_windows", WW'(got_q.size()), WW'(0));
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_valid_after_rst", WW'(OUT_VALID), WW'(0));
        #1;
        RST = 1'b0;
        for (int i = 0; i < 16; i++) src[i] = PIX_W'(50 + i);
        clear_lists();
        run(16, 0, 0, 200);
        if (got_q.size() > 0) begin
            chk("t6_first_window", got_q[0], lit9(50, 51, 52, 54, 55, 56, 58, 59, 60));
        end
        push_lit_4x4(50);
        cmp_list("t6_windows");
        chk("t6_done_pulses", WW'(done_cnt), WW'(1));

        repeat (3) @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
